// File: rtl/datagen_ctrl.sv
// datagen_ctrl: bus-programmable burst data generator driving an aes_core.
// Holds key/seed/config/count registers and produces N blocks in fixed,
// counter or Galois-LFSR mode. It sequences the core through init/next and
// buffers results in a FIFO that software pops through the RESULT address.
// Optional feature macro: DATAGEN_SIGNATURE_EN adds a rolling signature
// register readable at address 0x31 (reads 0 when the macro is undefined).
module datagen_ctrl #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [DATA_W-1:0] POLY       = 128'h87
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [7:0]        address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              core_init,
  output logic              core_next,
  output logic              core_encdec,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_block,
  input  logic              core_ready,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_result
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0a;
  localparam logic [7:0] ADDR_COUNT  = 8'h0b;
  localparam logic [7:0] ADDR_SEED   = 8'h0c;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_RESULT = 8'h30;
  localparam logic [7:0] ADDR_SIG    = 8'h31;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT       = 3'd1,
    ST_INIT_WAIT  = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_WAIT_VALID = 3'd4,
    ST_STORE      = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [DATA_W-1:0] key_r;
  logic [DATA_W-1:0] seed_r;
  logic [CNT_W-1:0]  count_r;
  logic [2:0]        config_r;
  logic [DATA_W-1:0] pattern_r;
  logic [CNT_W-1:0]  remaining_r;
  logic              infinite_r;
  logic              done_r;
  logic              busy_r;
  logic              core_init_r;
  logic              core_next_r;

  logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     fifo_count_r;

  logic              wr_s;
  logic              rd_s;
  logic              start_s;
  logic              abort_s;
  logic              idle_like_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              pop_s;
  logic              push_s;
  logic              launch_s;
  logic              last_s;
  logic [3:0]        level_s;
  logic [DATA_W-1:0] status_s;
  logic [DATA_W-1:0] sig_value_s;

  // Next pattern value after one block, by generation mode.
  function automatic logic [DATA_W-1:0] pattern_advance(input logic [DATA_W-1:0] p,
                                                        input logic [1:0]        mode);
    logic [DATA_W-1:0] shifted;
    shifted = {p[DATA_W-2:0], 1'b0};
    case (mode)
      2'd1:    pattern_advance = p + DATA_W'(1);
      2'd2:    pattern_advance = p[DATA_W-1] ? (shifted ^ POLY) : shifted;
      default: pattern_advance = p;
    endcase
  endfunction

  // First pattern of a burst; the LFSR must never start from the all-zero state.
  function automatic logic [DATA_W-1:0] pattern_load(input logic [DATA_W-1:0] s,
                                                     input logic [1:0]        mode);
    if ((mode == 2'd2) && (s == '0)) begin
      pattern_load = DATA_W'(1);
    end else begin
      pattern_load = s;
    end
  endfunction

  assign wr_s         = cs & we;
  assign rd_s         = cs & ~we;
  assign start_s      = wr_s && (address == ADDR_CTRL) && write_data[0];
  assign abort_s      = wr_s && (address == ADDR_CTRL) && write_data[1];
  assign idle_like_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign fifo_empty_s = (fifo_count_r == '0);
  assign fifo_full_s  = (fifo_count_r == CW'(FIFO_DEPTH));
  assign pop_s        = rd_s && (address == ADDR_RESULT) && !fifo_empty_s;
  assign last_s       = !infinite_r && (remaining_r == CNT_W'(1));
  assign level_s      = 4'(fifo_count_r);
  assign status_s     = DATA_W'({level_s, fifo_full_s, fifo_empty_s, done_r, busy_r});

  assign core_init   = core_init_r;
  assign core_next   = core_next_r;
  assign core_encdec = config_r[0];
  assign core_key    = key_r;
  assign core_block  = pattern_r;

  // Next-state decode, FIFO push request and burst launch; abort overrides all.
  always_comb begin
    state_t nxt;
    logic   psh;
    logic   lch;
    nxt = state_r;
    psh = 1'b0;
    lch = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          nxt = ST_INIT;
          lch = 1'b1;
        end else begin
          nxt = state_r;
        end
      end
      ST_INIT: nxt = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (core_ready) begin
          nxt = ST_ISSUE;
        end else begin
          nxt = ST_INIT_WAIT;
        end
      end
      ST_ISSUE: nxt = ST_WAIT_VALID;
      ST_WAIT_VALID: begin
        if (core_valid) begin
          nxt = ST_STORE;
        end else begin
          nxt = ST_WAIT_VALID;
        end
      end
      ST_STORE: begin
        // A pop in the same cycle frees a slot, so a full FIFO need not stall.
        if (!fifo_full_s || pop_s) begin
          psh = 1'b1;
          nxt = last_s ? ST_DONE : ST_ISSUE;
        end else begin
          nxt = ST_STORE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
    if (abort_s) begin
      state_next_s = ST_IDLE;
      push_s       = 1'b0;
      launch_s     = 1'b0;
    end else begin
      state_next_s = nxt;
      push_s       = psh;
      launch_s     = lch;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered core strobes and status flags, aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_init_r <= 1'b0;
      core_next_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      core_init_r <= (state_next_s == ST_INIT);
      core_next_r <= (state_next_s == ST_ISSUE);
      busy_r      <= !((state_next_s == ST_IDLE) || (state_next_s == ST_DONE));
      if (launch_s) begin
        done_r <= 1'b0;
      end else if ((state_next_s == ST_DONE) && (state_r != ST_DONE)) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

  // Software-visible configuration; key, seed and config are frozen during a burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_r    <= '0;
      seed_r   <= DATA_W'(1);
      count_r  <= CNT_W'(1);
      config_r <= 3'd0;
    end else if (wr_s) begin
      case (address)
        ADDR_KEY:    key_r    <= idle_like_s ? write_data : key_r;
        ADDR_SEED:   seed_r   <= idle_like_s ? write_data : seed_r;
        ADDR_CONFIG: config_r <= idle_like_s ? write_data[2:0] : config_r;
        ADDR_COUNT:  count_r  <= write_data[CNT_W-1:0];
        default:     count_r  <= count_r;
      endcase
    end else begin
      key_r <= key_r;
    end
  end

  // Burst datapath: load pattern/length on launch, step both on every stored block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_r   <= '0;
      remaining_r <= '0;
      infinite_r  <= 1'b0;
    end else if (launch_s) begin
      pattern_r   <= pattern_load(seed_r, config_r[2:1]);
      remaining_r <= count_r;
      infinite_r  <= (count_r == '0);
    end else if (push_s) begin
      pattern_r   <= pattern_advance(pattern_r, config_r[2:1]);
      remaining_r <= remaining_r - CNT_W'(1);
    end else begin
      pattern_r   <= pattern_r;
    end
  end

  // Result FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= core_result;
    end
  end

  // Result FIFO pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

`ifdef DATAGEN_SIGNATURE_EN
  logic [DATA_W-1:0] sig_r;

  // Rolling signature over every pushed result: rotate left by one, then XOR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_r <= '0;
    end else if (launch_s) begin
      sig_r <= '0;
    end else if (push_s) begin
      sig_r <= {sig_r[DATA_W-2:0], sig_r[DATA_W-1]} ^ core_result;
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig_value_s = sig_r;
`else
  assign sig_value_s = '0;
`endif

  // Bus read mux; reads return 0 unless selected for a read.
  always_comb begin
    read_data = '0;
    if (rd_s) begin
      case (address)
        ADDR_STATUS: read_data = status_s;
        ADDR_CONFIG: read_data = DATA_W'(config_r);
        ADDR_COUNT:  read_data = DATA_W'(count_r);
        ADDR_SEED:   read_data = seed_r;
        ADDR_KEY:    read_data = key_r;
        ADDR_RESULT: read_data = fifo_empty_s ? '0 : fifo_mem_r[rd_ptr_r];
        ADDR_SIG:    read_data = sig_value_s;
        default:     read_data = '0;
      endcase
    end else begin
      read_data = '0;
    end
  end

endmodule

// File: tb/tb_datagen_ctrl.sv
// Self-checking bench for datagen_ctrl with a behavioural block-cipher stand-in.
module tb_datagen_ctrl;
  localparam int DW = 128;
  localparam logic [7:0] A_CTRL = 8'h08, A_STATUS = 8'h09, A_CONFIG = 8'h0a, A_COUNT = 8'h0b;
  localparam logic [7:0] A_SEED = 8'h0c, A_KEY = 8'h10, A_RESULT = 8'h30, A_SIG = 8'h31;
  localparam logic [DW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cs, we;
  logic [7:0] address;
  logic [DW-1:0] write_data, read_data;
  logic core_init, core_next, core_encdec;
  logic [DW-1:0] core_key, core_block;
  logic core_ready, core_valid;
  logic [DW-1:0] core_result;

  int pass_cnt = 0;
  int total_cnt = 0;
  int init_lat = 2;
  int next_lat = 3;
  logic [DW-1:0] blk_log[$];

  datagen_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data),
    .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
    .core_key(core_key), .core_block(core_block),
    .core_ready(core_ready), .core_valid(core_valid), .core_result(core_result)
  );

  function automatic logic [DW-1:0] mock_cipher(input logic [DW-1:0] b, input logic [DW-1:0] k,
                                                input logic e);
    if (e && (b == FIPS_PT) && (k == FIPS_KEY)) return FIPS_CT;
    return b ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  // Core stand-in: ready/valid drop on a strobe and return after a latency.
  logic op_next;
  int lat_cnt;
  logic [DW-1:0] blk_q, key_q;
  logic enc_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      core_ready <= 1'b1; core_valid <= 1'b0; core_result <= '0; lat_cnt <= 0; op_next <= 1'b0;
    end else if (core_init) begin
      core_ready <= 1'b0; core_valid <= 1'b0; lat_cnt <= init_lat; op_next <= 1'b0;
    end else if (core_next) begin
      core_ready <= 1'b0; core_valid <= 1'b0; lat_cnt <= next_lat; op_next <= 1'b1;
      blk_q <= core_block; key_q <= core_key; enc_q <= core_encdec;
      blk_log.push_back(core_block);
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        core_ready <= 1'b1;
        if (op_next) begin
          core_valid  <= 1'b1;
          core_result <= mock_cipher(blk_q, key_q, enc_q);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [DW-1:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; address = 8'h00; write_data = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [DW-1:0] d);
    cs = 1'b1; we = 1'b0; address = a;
    #1 d = read_data;
    @(posedge clk); #1;
    cs = 1'b0; address = 8'h00;
  endtask

  task automatic wait_status(input int idx, input logic want, input int max_cyc, input string name);
    logic [DW-1:0] st;
    int n;
    n = 0;
    bus_read(A_STATUS, st);
    while ((st[idx] !== want) && (n < max_cyc)) begin
      bus_read(A_STATUS, st);
      n++;
    end
    check(name, DW'(st[idx]), DW'(want));
  endtask

  typedef struct {
    logic [2:0]          cfg;
    logic [DW-1:0]       seed;
    int                  n;
    logic [2:0][DW-1:0]  exp;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DW-1:0] d, r0, r1, sig_exp;
    int n;
    // {mode, encdec}, seed, length, expected core_block sequence
    vecs[0] = '{3'b010, 128'h0, 3, {128'h2, 128'h1, 128'h0}};
    vecs[1] = '{3'b100, 128'h0, 2, {128'h0, 128'h2, 128'h1}};
    vecs[2] = '{3'b100, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 2,
                {128'h0, 128'h87, 128'h8000_0000_0000_0000_0000_0000_0000_0000}};
    vecs[3] = '{3'b101, 128'hc000_0000_0000_0000_0000_0000_0000_0001, 2,
                {128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0085,
                 128'hc000_0000_0000_0000_0000_0000_0000_0001}};
    vecs[4] = '{3'b001, 128'hdeadbeef, 2, {128'h0, 128'hdeadbeef, 128'hdeadbeef}};
    vecs[5] = '{3'b110, 128'h1234, 2, {128'h0, 128'h1234, 128'h1234}};
    vecs[6] = '{3'b010, {DW{1'b1}}, 2, {128'h0, 128'h0, {DW{1'b1}}}};

    rst_n = 1'b0; cs = 1'b0; we = 1'b0; address = 8'h00; write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst core_init", DW'(core_init), '0);
    check("rst core_next", DW'(core_next), '0);
    check("rst core_encdec", DW'(core_encdec), '0);
    check("rst core_key", core_key, '0);
    check("rst core_block", core_block, '0);
    check("rst read_data idle", read_data, '0);
    bus_read(A_STATUS, d); check("rst status", d, 128'h4);
    bus_read(A_SEED, d);   check("rst seed", d, 128'h1);
    bus_read(A_COUNT, d);  check("rst count", d, 128'h1);
    bus_read(A_CONFIG, d); check("rst config", d, 128'h0);
    bus_read(A_SIG, d);    check("rst sig", d, 128'h0);
    cs = 1'b1; we = 1'b1; address = A_SEED; write_data = 128'h1;
    #1 check("read_data during write", read_data, '0);
    @(posedge clk); #1 cs = 1'b0; we = 1'b0;

    // FIPS-197 single block in fixed mode
    bus_write(A_KEY, FIPS_KEY);
    bus_write(A_SEED, FIPS_PT);
    bus_write(A_COUNT, 128'h1);
    bus_write(A_CONFIG, 128'h1);
    bus_write(A_CTRL, 128'h1);
    check("start->init latency", DW'(core_init), 128'h1);
    check("encdec", DW'(core_encdec), 128'h1);
    check("core_key", core_key, FIPS_KEY);
    wait_status(1, 1'b1, 200, "fips done");
    bus_read(A_STATUS, d); check("fips level", DW'(d[7:4]), 128'h1);
    bus_read(A_RESULT, d); check("fips result", d, FIPS_CT);
    bus_read(A_STATUS, d); check("fips status after pop", DW'(d[7:0]), 128'h6);

    // Table-driven pattern generation
    for (int v = 0; v < 7; v++) begin
      blk_log.delete();
      bus_write(A_CONFIG, DW'(vecs[v].cfg));
      bus_write(A_SEED, vecs[v].seed);
      bus_write(A_COUNT, DW'(vecs[v].n));
      bus_write(A_CTRL, 128'h1);
      wait_status(1, 1'b1, 300, $sformatf("v%0d done", v));
      bus_read(A_STATUS, d);
      check($sformatf("v%0d level", v), DW'(d[7:4]), DW'(vecs[v].n));
      check($sformatf("v%0d nblocks", v), DW'(blk_log.size()), DW'(vecs[v].n));
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i < blk_log.size()) check($sformatf("v%0d blk%0d", v, i), blk_log[i], vecs[v].exp[i]);
        bus_read(A_RESULT, d);
        check($sformatf("v%0d res%0d", v, i), d, mock_cipher(vecs[v].exp[i], FIPS_KEY, vecs[v].cfg[0]));
      end
      bus_read(A_RESULT, d); check($sformatf("v%0d empty pop", v), d, '0);
      bus_read(A_STATUS, d); check($sformatf("v%0d empty", v), DW'(d[2]), 128'h1);
    end

    // Stall on a full FIFO, then drain in order
    blk_log.delete();
    bus_write(A_CONFIG, 128'h2);
    bus_write(A_SEED, 128'd100);
    bus_write(A_COUNT, 128'd6);
    bus_write(A_CTRL, 128'h1);
    wait_status(3, 1'b1, 300, "stall full");
    repeat (10) @(posedge clk);
    #1;
    bus_read(A_STATUS, d);
    check("stall status", DW'(d[7:0]), 128'h49);
    check("stall issued", DW'(blk_log.size()), 128'd5);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_RESULT, d);
      check($sformatf("stall res%0d", i), d, mock_cipher(DW'(100 + i), FIPS_KEY, 1'b0));
    end
    for (int i = 4; i < 6; i++) begin
      wait_status(2, 1'b0, 100, $sformatf("stall avail%0d", i));
      bus_read(A_RESULT, d);
      check($sformatf("stall res%0d", i), d, mock_cipher(DW'(100 + i), FIPS_KEY, 1'b0));
    end
    wait_status(1, 1'b1, 100, "stall done");

    // Abort while waiting for valid
    next_lat = 8;
    blk_log.delete();
    bus_write(A_CONFIG, 128'h2);
    bus_write(A_SEED, 128'd7);
    bus_write(A_COUNT, 128'd2);
    bus_write(A_CTRL, 128'h1);
    n = 0;
    while ((core_next !== 1'b1) && (n < 50)) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort next seen", DW'(core_next), 128'h1);
    @(posedge clk); #1;
    bus_write(A_CTRL, 128'h1);
    check("start while busy", DW'(core_init), '0);
    bus_write(A_KEY, {DW{1'b1}});
    bus_write(A_CONFIG, 128'h4);
    bus_write(A_CTRL, 128'h2);
    bus_read(A_STATUS, d); check("abort status", DW'(d[7:0]), 128'h4);
    repeat (12) @(posedge clk);
    #1;
    bus_read(A_STATUS, d); check("abort no push", DW'(d[7:0]), 128'h4);
    check("key frozen", core_key, FIPS_KEY);
    bus_read(A_CONFIG, d); check("config frozen", d, 128'h2);
    check("abort issued", DW'(blk_log.size()), 128'd1);
    next_lat = 3;

    // Signature over a two-block counter burst
    bus_write(A_SEED, 128'd20);
    bus_write(A_CTRL, 128'h1);
    wait_status(1, 1'b1, 200, "sig done");
    r0 = mock_cipher(128'd20, FIPS_KEY, 1'b0);
    r1 = mock_cipher(128'd21, FIPS_KEY, 1'b0);
`ifdef DATAGEN_SIGNATURE_EN
    sig_exp = {r0[126:0], r0[127]} ^ r1;
`else
    sig_exp = '0;
`endif
    bus_read(A_SIG, d); check("signature", d, sig_exp);
    bus_read(A_RESULT, d); check("sig res0", d, r0);
    bus_read(A_RESULT, d); check("sig res1", d, r1);

    // Reset in the middle of a burst flushes everything
    bus_write(A_SEED, 128'd50);
    bus_write(A_COUNT, 128'd3);
    bus_write(A_CTRL, 128'h1);
    wait_status(2, 1'b0, 200, "midrst entry");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(A_STATUS, d); check("midrst status", d, 128'h4);
    bus_read(A_SEED, d);   check("midrst seed", d, 128'h1);
    bus_read(A_RESULT, d); check("midrst pop", d, '0);
    check("midrst key", core_key, '0);
    check("midrst block", core_block, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
